// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// Moore outputs decoded from State (IRWrite/PCWrite in FETCH also gated by MemReady).
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUop,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;
  logic   illegal_q, set_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    set_illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d     = S_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUop       = 3'b000;
    InstrDone   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 3'b001;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      // Zero is resolved outside; only the conditional write enable is raised here
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 3'b010;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        InstrDone   = 1'b1;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        InstrDone = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign State   = state_q;
  assign Illegal = illegal_q;

endmodule
